pwm_dimmer: RTL and testbench

Multi-channel PWM brightness controller with push-button up/down stepping, per-channel duty registers and glitch-free duty updates. It drives up to CH LED outputs from a shared PWM period counter and replaces the single-channel, wrap-around key dimmer. Keys are sampled on a slow step tick, so holding a key ramps the duty smoothly. Duty saturates at both ends.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_chan.sv | 44 ++++
 rtl/pwm_dimmer.sv | 193 +++++++++++++++++++
 tb/tb_pwm_dimmer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dimmer: parameter defaults, raw key codes
// and the saturating duty step helper.
package pwm_pkg;

    localparam int unsigned DW_DEF       = 10;
    localparam int unsigned PRE_LOG_DEF  = 4;
    localparam int unsigned STEP_LOG_DEF = 15;

    // Widest duty the step helper handles.
    localparam int unsigned SAT_W = 16;

    // Raw active-low key codes: key[0] = up, key[1] = down.
    localparam logic [1:0] KEY_UP = 2'b10;
    localparam logic [1:0] KEY_DN = 2'b01;

    // One +/-1 step clamped to [0, max]; both or neither request holds the value.
    function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] val,
                                                  input logic [SAT_W-1:0] max,
                                                  input logic             inc,
                                                  input logic             dec);
        logic [SAT_W-1:0] res;
        res = val;
        if (inc && !dec && (val < max)) begin
            res = val + SAT_W'(1);
        end else if (dec && !inc && (val != '0)) begin
            res = val - SAT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow duty, period-aligned active duty and output compare.
module pwm_chan import pwm_pkg::*; #(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] per_cnt,
    input  logic          period_end,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] shadow,
    output logic          pwm
);

    logic [DW-1:0] active;

    // Shadow duty takes key/breathe updates at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (we) begin
            shadow <= wdata;
        end
    end

    // Active duty only changes at the period wrap, so no period is ever cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
        end else if (period_end) begin
            active <= shadow;
        end
    end

    // Registered compare output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (per_cnt < active);
        end
    end

endmodule

// File: rtl/pwm_dimmer.sv
// Multi-channel PWM dimmer with debounced up/down keys and saturating duty.
// Optional breathe ramp is built only when PWM_BREATHE_EN is defined.
module pwm_dimmer import pwm_pkg::*; #(
    parameter int unsigned CH       = 4,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned PRE_LOG  = PRE_LOG_DEF,
    parameter int unsigned STEP_LOG = STEP_LOG_DEF,
    localparam int unsigned SELW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      key,
    input  logic [SELW-1:0] ch_sel,
    input  logic            mode,
    output logic [CH-1:0]   pwm,
    output logic [DW-1:0]   duty_o
);

    localparam logic [STEP_LOG-1:0] PRE_MASK = STEP_LOG'((1 << PRE_LOG) - 1);
    localparam logic [DW-1:0]       DUTY_MAX = '1;

    logic [STEP_LOG-1:0] div_cnt;
    logic [DW-1:0]       per_cnt;
    logic                tick_pwm;
    logic                tick_step;
    logic                period_end;

    logic [1:0] key_s1;
    logic [1:0] key_s2;
    logic [1:0] key_prev;
    logic       up_hit;
    logic       dn_hit;

    logic          step_inc;
    logic          step_dec;
    logic          step_all;
    logic [CH-1:0] sel_hit;
    logic [CH-1:0] we;
    logic [DW-1:0] wdata  [CH];
    logic [DW-1:0] shadow [CH];

    assign tick_pwm   = &(div_cnt | ~PRE_MASK);
    assign tick_step  = &div_cnt;
    assign period_end = tick_pwm && (&per_cnt);

    // Free-running clock divider and PWM period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            per_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + STEP_LOG'(1);
            if (tick_pwm) begin
                per_cnt <= per_cnt + DW'(1);
            end
        end
    end

    // Two-flop key synchroniser plus the previous step sample for debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            if (tick_step) begin
                key_prev <= key_s2;
            end
        end
    end

    // A key counts only when low in this and the previous step sample.
    assign up_hit = ((key_s2 | KEY_UP) == KEY_UP) && ((key_prev | KEY_UP) == KEY_UP);
    assign dn_hit = ((key_s2 | KEY_DN) == KEY_DN) && ((key_prev | KEY_DN) == KEY_DN);

`ifdef PWM_BREATHE_EN
    localparam logic [1:0] BR_UP  = 2'd0;
    localparam logic [1:0] BR_TOP = 2'd1;
    localparam logic [1:0] BR_DN  = 2'd2;
    localparam logic [1:0] BR_BOT = 2'd3;

    logic [1:0]    br_state;
    logic [1:0]    br_state_nxt;
    logic [DW-1:0] br_lvl;
    logic [DW-1:0] br_lvl_nxt;
    logic          br_inc;
    logic          br_dec;

    // Breathe state and reference level advance once per step tick in mode 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_state <= BR_UP;
            br_lvl   <= '0;
        end else if (tick_step && mode) begin
            br_state <= br_state_nxt;
            br_lvl   <= br_lvl_nxt;
        end
    end

    // Triangle ramp: climb, hold one tick at top, descend, hold one tick at 0.
    always_comb begin
        br_state_nxt = br_state;
        br_lvl_nxt   = br_lvl;
        br_inc       = 1'b0;
        br_dec       = 1'b0;
        case (br_state)
            BR_UP: begin
                br_inc     = 1'b1;
                br_lvl_nxt = br_lvl + DW'(1);
                if (br_lvl == DUTY_MAX - DW'(1)) begin
                    br_state_nxt = BR_TOP;
                end
            end
            BR_TOP: begin
                br_state_nxt = BR_DN;
            end
            BR_DN: begin
                br_dec     = 1'b1;
                br_lvl_nxt = br_lvl - DW'(1);
                if (br_lvl == DW'(1)) begin
                    br_state_nxt = BR_BOT;
                end
            end
            default: begin
                br_state_nxt = BR_UP;
            end
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Step request: keys act on one channel, breathe acts on all of them.
    always_comb begin
        step_inc = up_hit && !dn_hit;
        step_dec = dn_hit && !up_hit;
        step_all = 1'b0;
`ifdef PWM_BREATHE_EN
        if (mode) begin
            step_inc = br_inc;
            step_dec = br_dec;
            step_all = 1'b1;
        end
`endif
    end

    // Channel decode; an out-of-range ch_sel matches nothing.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < CH; i++) begin
            sel_hit[i] = (ch_sel == SELW'(i));
        end
    end

    // Per-channel write enable and saturated next duty.
    always_comb begin
        we    = '0;
        wdata = '{default: '0};
        for (int i = 0; i < CH; i++) begin
            wdata[i] = DW'(sat_step(SAT_W'(shadow[i]), SAT_W'(DUTY_MAX), step_inc, step_dec));
            we[i]    = tick_step && (step_all || sel_hit[i]) && (step_inc || step_dec);
        end
    end

    // Selected channel's shadow duty, zero when ch_sel is out of range.
    always_comb begin
        duty_o = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel_hit[i]) begin
                duty_o = shadow[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pwm_chan #(
            .DW(DW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .per_cnt    (per_cnt),
            .period_end (period_end),
            .we         (we[g]),
            .wdata      (wdata[g]),
            .shadow     (shadow[g]),
            .pwm        (pwm[g])
        );
    end

endmodule

// File: tb/tb_pwm_dimmer.sv
// Scoreboard bench for pwm_dimmer: a step/period-level model queues expected
// active duties and duty_o values, a monitor checks the pwm waveform shape.
module tb_pwm_dimmer;

    localparam int unsigned CH       = 3;
    localparam int unsigned DW       = 4;
    localparam int unsigned PRE_LOG  = 1;
    localparam int unsigned STEP_LOG = 6;
    localparam int TICK_CLK = 1 << PRE_LOG;
    localparam int PER_CLK  = 1 << (DW + PRE_LOG);
    localparam int STEP_CLK = 1 << STEP_LOG;
    localparam int DMAX     = (1 << DW) - 1;
    localparam int NSTEP    = 110;
    localparam int NWIN     = 2 * NSTEP;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic [1:0]    key    = 2'b11;
    logic [1:0]    ch_sel = 2'd0;
    logic          mode   = 1'b0;
    logic [CH-1:0] pwm;
    logic [DW-1:0] duty_o;

    pwm_dimmer #(
        .CH(CH), .DW(DW), .PRE_LOG(PRE_LOG), .STEP_LOG(STEP_LOG)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .ch_sel(ch_sel),
        .mode(mode), .pwm(pwm), .duty_o(duty_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pq[$];
    int dq[$];
    bit mon_done = 1'b0;

    // Reference model state
    int         sh[CH];
    logic [1:0] prev_k = 2'b00;
    int         bp = 0;
    int         last_act[CH];

    // Stimulus schedule, one entry per step interval
    logic [1:0] key_s [NSTEP];
    int         sel_s [NSTEP];
    logic       mode_s[NSTEP];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tri_lvl(input int p);
        int q;
        q = p % (2 * (DMAX + 1));
        return (q <= DMAX) ? q : (2 * DMAX + 1 - q);
    endfunction

    // Key rule at a step tick: a press needs two consecutive low samples.
    task automatic model_tick(input logic [1:0] k, input int s);
        bit up;
        bit dn;
        up     = !k[0] && !prev_k[0];
        dn     = !k[1] && !prev_k[1];
        prev_k = k;
`ifdef PWM_BREATHE_EN
        if (mode) begin
            int d;
            d = tri_lvl(bp + 1) - tri_lvl(bp);
            bp++;
            for (int c = 0; c < CH; c++) begin
                sh[c] = sh[c] + d;
                if (sh[c] > DMAX) sh[c] = DMAX;
                if (sh[c] < 0) sh[c] = 0;
            end
            return;
        end
`endif
        if (s < CH) begin
            if (up && !dn && sh[s] < DMAX) sh[s] = sh[s] + 1;
            else if (dn && !up && sh[s] > 0) sh[s] = sh[s] - 1;
        end
    endtask

    task automatic sched(input int from, input int len, input logic [1:0] k, input int s, input logic m);
        for (int j = from; j < from + len && j < NSTEP; j++) begin
            key_s[j]  = k;
            sel_s[j]  = s;
            mode_s[j] = m;
        end
    endtask

    // Build schedule, then drive it while feeding the scoreboard.
    initial begin
        int j;
        sched(0, 2, 2'b11, 2, 1'b0);
        sched(2, 20, 2'b10, 2, 1'b0);   // ramp ch2 to the top and hold there
        sched(22, 1, 2'b11, 1, 1'b0);
        sched(23, 1, 2'b10, 1, 1'b0);   // one-sample glitch
        sched(24, 1, 2'b11, 1, 1'b0);
        sched(25, 3, 2'b01, 0, 1'b0);   // down from zero
        sched(28, 20, 2'b01, 2, 1'b0);  // ch2 back to zero
        sched(48, 6, 2'b10, 1, 1'b0);
        sched(54, 5, 2'b00, 1, 1'b0);   // both keys held
        sched(59, 3, 2'b10, 3, 1'b0);   // out-of-range channel
        j = 62;
        while (j < NSTEP - 4) begin
            int len;
            int r;
            logic [1:0] k;
            len = $urandom_range(1, 8);
            r   = $urandom_range(0, 99);
            k   = (r < 40) ? 2'b10 : (r < 70) ? 2'b01 : (r < 85) ? 2'b11 : 2'b00;
`ifdef PWM_BREATHE_EN
            sched(j, len, k, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
`else
            sched(j, len, k, $urandom_range(0, 3), 1'b0);
`endif
            j += len;
        end
        sched(NSTEP - 4, 4, 2'b10, 0, 1'b0);

        for (int c = 0; c < CH; c++) begin
            sh[c] = 0;
            pq.push_back(0);
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int c = 0; c < NSTEP * STEP_CLK; c++) begin
            if (c % STEP_CLK == 0) begin
                int s;
                s      = sel_s[c / STEP_CLK];
                key    = key_s[c / STEP_CLK];
                ch_sel = 2'(s);
                mode   = mode_s[c / STEP_CLK];
                dq.push_back((s < CH) ? sh[s] : 0);
            end
            if (c % PER_CLK == PER_CLK - 1) begin
                for (int i = 0; i < CH; i++) begin
                    pq.push_back(sh[i]);
                    last_act[i] = sh[i];
                end
                if (c % STEP_CLK == STEP_CLK - 1) begin
                    model_tick(key, int'(ch_sel));
                end
            end
            @(negedge clk);
        end

        // Mid-period reset forces pwm low on the next clock.
        ch_sel = 2'd0;
        mode   = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_pwm0", int'(pwm[0]), (last_act[0] > 0) ? 1 : 0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_duty_o", int'(duty_o), 0);

        for (int i = 0; i < 1000 && !mon_done; i++) @(negedge clk);
        if (!mon_done) check("monitor_done", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Monitor: per period window, compare pwm shape and high time with the model.
    initial begin
        int exp_a[CH];
        int hi[CH];
        int bad[CH];
        wait (rst == 1'b0);
        @(negedge clk);
        check("reset_release_pwm", int'(pwm), 0);
        check("reset_release_duty_o", int'(duty_o), 0);
        for (int c = 1; c <= NWIN * PER_CLK; c++) begin
            int off;
            @(negedge clk);
            off = (c - 1) % PER_CLK;
            if (off == 0) begin
                for (int i = 0; i < CH; i++) begin
                    hi[i]  = 0;
                    bad[i] = 0;
                    if (pq.size() == 0) begin
                        check("active_queue_empty", 1, 0);
                        exp_a[i] = 0;
                    end else begin
                        exp_a[i] = pq.pop_front();
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                int eb;
                eb = ((off / TICK_CLK) < exp_a[i]) ? 1 : 0;
                if (int'(pwm[i]) != eb) bad[i]++;
                if (pwm[i]) hi[i]++;
            end
            if (off == PER_CLK - 1) begin
                for (int i = 0; i < CH; i++) begin
                    check($sformatf("pwm%0d_high_period%0d", i, (c - 1) / PER_CLK), hi[i], exp_a[i] * TICK_CLK);
                    check($sformatf("pwm%0d_shape_errs_period%0d", i, (c - 1) / PER_CLK), bad[i], 0);
                end
            end
            if (c % STEP_CLK == STEP_CLK / 2) begin
                if (dq.size() == 0) check("duty_queue_empty", 1, 0);
                else check($sformatf("duty_o_step%0d", c / STEP_CLK), int'(duty_o), dq.pop_front());
            end
        end
        mon_done = 1'b1;
    end

endmodule
